vram_scanout: RTL and testbench
===============================

VRAM_SCANOUT -- requirements
Module: vram_scanout

Interface
REQ-001 Parameters SHALL be: DISPLAY_WIDTH, 240, pixels per row; DISPLAY_HEIGHT, 320, rows per frame; VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, frame words.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-004 Further ports SHALL be: ena input 1 read-issue enable; start input 1 frame request pulse; busy output 1 frame in progress.
REQ-005 VRAM ports SHALL be: vram_rd_addr output $clog2(VRAM_L) read address; vram_rd_data input 16 ILI9341_color_t, valid one cycle after the address.
REQ-006 Stream ports SHALL be: pixel_data output 16 color; pixel_valid output 1; pixel_ready input 1; pixel_last output 1 marks the final frame pixel; frame_done output 1 single-cycle pulse.

Function
REQ-007 The FSM SHALL have states S_IDLE, S_SCAN and S_DRAIN.
REQ-008 S_IDLE SHALL go to S_SCAN on start; the read address SHALL be zeroed on the same edge.
REQ-009 S_SCAN SHALL go to S_DRAIN after address VRAM_L-1 is issued.
REQ-010 S_DRAIN SHALL go to S_IDLE when the buffer is empty and no read is in flight; frame_done SHALL pulse high for that one transition cycle.
REQ-011 busy SHALL be high in S_SCAN and S_DRAIN, and low in S_IDLE.
REQ-012 Addresses SHALL be row-major, addr = y*DISPLAY_WIDTH + x. They SHALL be generated by an incrementing counter with x/y sub-counters; no multiplier is allowed.
REQ-013 x SHALL wrap at DISPLAY_WIDTH-1 to 0, and y SHALL increment on each x wrap.
REQ-014 A read SHALL be issued in a cycle only when all of these hold: S_SCAN; ena=1; (occupancy + in_flight - pop) < 2.
  - pop = pixel_valid & pixel_ready.
REQ-015 Returned read data SHALL be captured one cycle after issue into a 2-entry FIFO; in_flight is at most 1.
REQ-016 pixel_valid SHALL equal FIFO non-empty. pixel_data and pixel_last SHALL come from the FIFO head.
REQ-017 A pixel SHALL transfer only on pixel_valid & pixel_ready.
REQ-018 Once pixel_valid is asserted, pixel_data and pixel_valid SHALL stay stable until the transfer.
REQ-019 With pixel_ready held at 1 and ena=1, throughput SHALL be 1 pixel/cycle. First pixel_valid SHALL come 2 cycles after start is sampled.
REQ-020 Simultaneous push and pop SHALL leave the occupancy unchanged; no pixel is lost or duplicated.
REQ-021 ena=0 SHALL stop new reads only. The in-flight read SHALL still land, and buffered pixels SHALL still drain.
REQ-022 start while busy SHALL be ignored.
REQ-023 pixel_last SHALL be set only on the pixel from address VRAM_L-1.

Reset
REQ-024 On rst the block SHALL return to S_IDLE. Address, x and y SHALL be 0. The FIFO SHALL be empty and in_flight 0.
REQ-025 After rst: busy=0, pixel_valid=0, pixel_last=0, frame_done=0, pixel_data=0, vram_rd_addr=0.
REQ-026 rst in mid-frame SHALL discard buffered and in-flight data. No frame_done SHALL be emitted for the aborted frame.

Configuration
REQ-027 With VRAM_SCANOUT_COORDS_EN defined, the block SHALL add these ports, travelling through the FIFO aligned with pixel_data:
  - pixel_x output $clog2(DISPLAY_WIDTH);
  - pixel_y output $clog2(DISPLAY_HEIGHT).
  Their reset value SHALL be 0.
REQ-028 Without VRAM_SCANOUT_COORDS_EN, those ports and their FIFO storage SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-029 ILI9341_color_t and the display geometry constants SHALL come from the shared ili9341_defines package. The FSM state enum SHALL be local.
REQ-030 The 2-entry FIFO SHALL be a sub-module named scanout_fifo2, parameterised by data width.
REQ-031 The read port SHALL connect directly to block_ram rd_addr/rd_data, with 1-cycle latency.

Verification (DISPLAY_WIDTH=4, DISPLAY_HEIGHT=3, RAM word n = n)
REQ-032 Scenario 1: start, pixel_ready=1 -> data 0..11 on consecutive cycles; pixel_last with 11; frame_done one cycle after the last transfer; busy then low.
REQ-033 Scenario 2: pixel_ready toggling 1,0,0,1 repeatedly -> all 12 values in order with no duplicates; data held stable while ready=0.
REQ-034 Scenario 3: ena=0 for cycles 3-6 after start -> no new addresses issued in that window; full sequence 0..11 still delivered.
REQ-035 Scenario 4: rst after the 5th transfer, then start -> pixel_valid drops next cycle; no frame_done; new frame restarts at 0.
REQ-036 Scenario 5: start pulsed again while busy -> ignored; exactly one frame_done.
REQ-037 Scenario 6 (COORDS_EN): value 6 -> pixel_x=2, pixel_y=1; value 11 -> pixel_x=3, pixel_y=2.

Source files
------------

// File: rtl/ili9341_defines.sv
// Shared ILI9341 panel definitions: pixel colour type and native display geometry.
package ili9341_defines;

  typedef logic [15:0] ILI9341_color_t;

  localparam int unsigned ILI9341_TFTWIDTH  = 240;
  localparam int unsigned ILI9341_TFTHEIGHT = 320;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scanout_fifo2.sv
// Two-entry FIFO between the VRAM read return and the pixel stream; head is registered.
module scanout_fifo2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/vram_scanout.sv
// Streams one frame of VRAM out as a valid/ready pixel stream in row-major order.
// Define VRAM_SCANOUT_COORDS_EN to add pixel_x/pixel_y outputs aligned with pixel_data.
module vram_scanout
  import ili9341_defines::*;
#(
  parameter  int unsigned DISPLAY_WIDTH  = ILI9341_TFTWIDTH,
  parameter  int unsigned DISPLAY_HEIGHT = ILI9341_TFTHEIGHT,
  parameter  int unsigned VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int unsigned AW             = clog2_min1(VRAM_L),
  localparam int unsigned XW             = clog2_min1(DISPLAY_WIDTH),
  localparam int unsigned YW             = clog2_min1(DISPLAY_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
  output logic           busy,
  output logic [AW-1:0]  vram_rd_addr,
  input  ILI9341_color_t vram_rd_data,
  output ILI9341_color_t pixel_data,
  output logic           pixel_valid,
  input  logic           pixel_ready,
  output logic           pixel_last,
  output logic           frame_done
`ifdef VRAM_SCANOUT_COORDS_EN
  ,
  output logic [XW-1:0]  pixel_x,
  output logic [YW-1:0]  pixel_y
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_e;

  localparam logic [AW-1:0] ADDR_LAST = AW'(VRAM_L - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(DISPLAY_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(DISPLAY_HEIGHT - 1);

`ifdef VRAM_SCANOUT_COORDS_EN
  localparam int unsigned FIFO_W = 17 + XW + YW;
`else
  localparam int unsigned FIFO_W = 17;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            in_flight_q, in_flight_d;
  logic            inf_last_q, inf_last_d;
`ifdef VRAM_SCANOUT_COORDS_EN
  logic [XW-1:0]   inf_x_q, inf_x_d;
  logic [YW-1:0]   inf_y_q, inf_y_d;
`endif

  logic              pop;
  logic              issue;
  logic [2:0]        occ_next;
  logic [1:0]        fifo_count;
  logic              fifo_not_empty;
  logic [FIFO_W-1:0] fifo_push_data;
  logic [FIFO_W-1:0] fifo_head;

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign pop      = pixel_valid & pixel_ready;
  assign occ_next = {1'b0, fifo_count} + {2'b0, in_flight_q} - {2'b0, pop};
  assign issue    = (state_q == S_SCAN) && ena && (occ_next < 3'd2);

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (issue && (addr_q == ADDR_LAST)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_count == 2'd0) && !in_flight_q) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    in_flight_d = issue;
    inf_last_d  = inf_last_q;
`ifdef VRAM_SCANOUT_COORDS_EN
    inf_x_d     = inf_x_q;
    inf_y_d     = inf_y_q;
`endif
    if ((state_q == S_IDLE) && start) begin
      addr_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (issue) begin
      inf_last_d = (addr_q == ADDR_LAST);
`ifdef VRAM_SCANOUT_COORDS_EN
      inf_x_d    = x_q;
      inf_y_d    = y_q;
`endif
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      in_flight_q <= 1'b0;
      inf_last_q  <= 1'b0;
`ifdef VRAM_SCANOUT_COORDS_EN
      inf_x_q     <= '0;
      inf_y_q     <= '0;
`endif
    end else begin
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      in_flight_q <= in_flight_d;
      inf_last_q  <= inf_last_d;
`ifdef VRAM_SCANOUT_COORDS_EN
      inf_x_q     <= inf_x_d;
      inf_y_q     <= inf_y_d;
`endif
    end
  end

  // Read data lands one cycle after issue, so the in-flight flag is the push strobe.
`ifdef VRAM_SCANOUT_COORDS_EN
  assign fifo_push_data = {inf_y_q, inf_x_q, inf_last_q, vram_rd_data};
`else
  assign fifo_push_data = {inf_last_q, vram_rd_data};
`endif

  scanout_fifo2 #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (fifo_push_data),
    .pop       (pop),
    .head_data (fifo_head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign vram_rd_addr = addr_q;
  assign pixel_valid  = fifo_not_empty;
  assign pixel_data   = fifo_head[15:0];
  assign pixel_last   = fifo_head[16] & fifo_not_empty;
`ifdef VRAM_SCANOUT_COORDS_EN
  assign pixel_x      = fifo_head[17 +: XW];
  assign pixel_y      = fifo_head[17 + XW +: YW];
`endif

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout on a 4x3 frame with a 1-cycle RAM returning word n = n.
module tb_vram_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        start;
  logic        busy;
  logic [3:0]  vram_rd_addr;
  logic [15:0] vram_rd_data = '0;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_last;
  logic        frame_done;
`ifdef VRAM_SCANOUT_COORDS_EN
  logic [1:0]  pixel_x;
  logic [1:0]  pixel_y;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) vram_rd_data <= {12'd0, vram_rd_addr};

  vram_scanout #(
    .DISPLAY_WIDTH (4),
    .DISPLAY_HEIGHT(3),
    .VRAM_L        (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .start        (start),
    .busy         (busy),
    .vram_rd_addr (vram_rd_addr),
    .vram_rd_data (vram_rd_data),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .pixel_last   (pixel_last),
    .frame_done   (frame_done)
`ifdef VRAM_SCANOUT_COORDS_EN
    ,
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,1; 2: ena low k=3..6; 3: extra start pulses while busy
  task automatic run_frame(input int mode);
    int          idx;
    int          dones;
    logic        held;
    logic [15:0] held_data;
    logic [3:0]  pat;
    idx   = 0;
    dones = 0;
    held  = 1'b0;
    held_data = '0;
    pat   = 4'b1001;
    ena   = 1'b1;
    pixel_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      ena         = !(mode == 2 && k >= 3 && k <= 6);
      pixel_ready = (mode == 1) ? pat[3 - ((k - 1) % 4)] : 1'b1;
      start       = (mode == 3 && (k == 5 || k == 9));
      if (mode == 2 && (k == 3 || k == 7)) check("ena_gap_addr", 32'(vram_rd_addr), 32'd2);
      if (held) begin
        check("hold_valid", 32'(pixel_valid), 32'd1);
        check("hold_data", 32'(pixel_data), 32'(held_data));
        held = 1'b0;
      end
      if (pixel_valid && !pixel_ready) begin
        held      = 1'b1;
        held_data = pixel_data;
      end
      if (pixel_valid && pixel_ready) begin
        check("seq_data", 32'(pixel_data), 32'(idx));
        check("seq_last", 32'(pixel_last), 32'(idx == 11));
`ifdef VRAM_SCANOUT_COORDS_EN
        check("seq_x", 32'(pixel_x), 32'(idx % 4));
        check("seq_y", 32'(pixel_y), 32'(idx / 4));
`endif
        idx++;
      end
      if (frame_done) begin
        dones++;
        check("done_after_all", 32'(idx), 32'd12);
      end
      step();
    end
    start = 1'b0;
    ena   = 1'b1;
    check("frame_count", 32'(idx), 32'd12);
    check("done_once", 32'(dones), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(pixel_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_last", 32'(pixel_last), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_data", 32'(pixel_data), 32'd0);
    check("rst_addr", 32'(vram_rd_addr), 32'd0);
`ifdef VRAM_SCANOUT_COORDS_EN
    check("rst_x", 32'(pixel_x), 32'd0);
    check("rst_y", 32'(pixel_y), 32'd0);
`endif

    // Scenario 1: exact latency and back-to-back throughput
    pixel_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_valid_k1", 32'(pixel_valid), 32'd0);
    step();
    check("s1_valid_k2", 32'(pixel_valid), 32'd0);
    step();
    for (int i = 0; i < 12; i++) begin
      check("s1_valid", 32'(pixel_valid), 32'd1);
      check("s1_data", 32'(pixel_data), 32'(i));
      check("s1_last", 32'(pixel_last), 32'(i == 11));
      check("s1_no_done", 32'(frame_done), 32'd0);
`ifdef VRAM_SCANOUT_COORDS_EN
      if (i == 6) begin
        check("s6_x6", 32'(pixel_x), 32'd2);
        check("s6_y6", 32'(pixel_y), 32'd1);
      end
      if (i == 11) begin
        check("s6_x11", 32'(pixel_x), 32'd3);
        check("s6_y11", 32'(pixel_y), 32'd2);
      end
`endif
      step();
    end
    check("s1_done", 32'(frame_done), 32'd1);
    check("s1_busy_drain", 32'(busy), 32'd1);
    check("s1_valid_end", 32'(pixel_valid), 32'd0);
    step();
    check("s1_done_clear", 32'(frame_done), 32'd0);
    check("s1_busy_end", 32'(busy), 32'd0);

    // Scenario 2: ready toggling 1,0,0,1
    run_frame(1);

    // Scenario 3: ena gap
    run_frame(2);

    // Scenario 4: reset mid-frame after 5 transfers
    pixel_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("s4_data", 32'(pixel_data), 32'(i));
      step();
    end
    rst = 1'b1;
    pixel_ready = 1'b0;
    check("s4_done_rst", 32'(frame_done), 32'd0);
    step();
    rst = 1'b0;
    check("s4_valid", 32'(pixel_valid), 32'd0);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_addr", 32'(vram_rd_addr), 32'd0);
    check("s4_data_rst", 32'(pixel_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("s4_no_done", 32'(frame_done), 32'd0);
      step();
    end
    run_frame(0);

    // Scenario 5: start while busy is ignored
    run_frame(3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
